// File: rtl/chnl_arbiter.sv
// Three-channel arbiter feeding a packet formatter: priority selection with
// round-robin tie-break, per-grant pkglen latch and a saturating grant counter.
module chnl_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          slv0_req_i,
  input  logic          slv0_val_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [1:0]    slv0_prio_i,
  input  logic [2:0]    slv0_pkglen_i,
  input  logic          slv1_req_i,
  input  logic          slv1_val_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic [1:0]    slv1_prio_i,
  input  logic [2:0]    slv1_pkglen_i,
  input  logic          slv2_req_i,
  input  logic          slv2_val_i,
  input  logic [DW-1:0] slv2_data_i,
  input  logic [1:0]    slv2_prio_i,
  input  logic [2:0]    slv2_pkglen_i,
  output logic          a2s0_ack_o,
  output logic          a2s1_ack_o,
  output logic          a2s2_ack_o,
  input  logic          f2a_ack_i,
  input  logic          f2a_id_req_i,
  output logic [1:0]    a2f_id_o,
  output logic          a2f_val_o,
  output logic [DW-1:0] a2f_data_o,
  output logic [2:0]    a2f_pkglen_sel_o,
  output logic [15:0]   grant_cnt_o
);

  typedef enum logic [1:0] {IDLE, ARB, BUSY, REL} state_e;

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [2:0]           pk_q, pk_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [2:0]           req, val, ack;
  logic [2:0][DW-1:0]   data;
  logic [2:0][1:0]      prio;
  logic [2:0][2:0]      pkglen;
  logic [1:0]           min_prio;
  logic                 win_vld;
  logic [1:0]           win_id;
  logic                 busy;

  assign req    = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign val    = {slv2_val_i, slv1_val_i, slv0_val_i};
  assign data   = {slv2_data_i, slv1_data_i, slv0_data_i};
  assign prio   = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
  assign pkglen = {slv2_pkglen_i, slv1_pkglen_i, slv0_pkglen_i};

  // Lowest prio value wins; scan starts at the channel after the last grant.
  always_comb begin
    min_prio = 2'd3;
    win_vld  = 1'b0;
    win_id   = 2'd0;
    for (int i = 0; i < 3; i++)
      if (req[i] && prio[i] < min_prio) min_prio = prio[i];
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (int'(last_q) + k) % 3;
      if (!win_vld && req[c] && prio[c] == min_prio) begin
        win_vld = 1'b1;
        win_id  = 2'(c);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b11;
      last_q  <= 2'd2;
      pk_q    <= 3'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pk_q    <= pk_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pk_d    = pk_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (win_vld) begin
          state_d = BUSY;
          grant_d = win_id;
          last_d  = win_id;
          pk_d    = pkglen[win_id];
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: if (f2a_id_req_i) state_d = REL;
      REL: begin
        state_d = IDLE;
        grant_d = 2'b11;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks the outputs immediately, not only after the next edge.
  always_comb begin
    busy             = (state_q == BUSY) && !rst_i;
    a2f_id_o         = 2'b11;
    a2f_val_o        = 1'b0;
    a2f_data_o       = '0;
    ack              = '0;
    a2f_pkglen_sel_o = rst_i ? 3'd3 : pk_q;
    if (busy && grant_q != 2'b11) begin
      a2f_id_o     = grant_q;
      a2f_val_o    = val[grant_q];
      a2f_data_o   = data[grant_q];
      ack[grant_q] = f2a_ack_i;
    end
  end

  assign a2s0_ack_o  = ack[0];
  assign a2s1_ack_o  = ack[1];
  assign a2s2_ack_o  = ack[2];
  assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_chnl_arbiter.sv
// Randomized + directed bench for chnl_arbiter against a transaction-level
// reference model (phase, winner by sort key, counters).
module tb_chnl_arbiter;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [2:0]    req, val, ack_o;
  logic [DW-1:0] data [3];
  logic [1:0]    prio [3];
  logic [2:0]    pkg  [3];
  logic          f2a_ack, f2a_id_req;
  logic [1:0]    id_o;
  logic          val_o;
  logic [DW-1:0] data_o;
  logic [2:0]    pk_o;
  logic [15:0]   cnt_o;

  int n_cmp = 0, n_err = 0;
  // model: phase 0 idle, 1 arb, 2 busy, 3 release
  int mst, mgrant, mlast, mpk, mcnt;

  always #5 clk_i = ~clk_i;

  chnl_arbiter #(.DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv0_req_i(req[0]), .slv0_val_i(val[0]), .slv0_data_i(data[0]),
    .slv0_prio_i(prio[0]), .slv0_pkglen_i(pkg[0]),
    .slv1_req_i(req[1]), .slv1_val_i(val[1]), .slv1_data_i(data[1]),
    .slv1_prio_i(prio[1]), .slv1_pkglen_i(pkg[1]),
    .slv2_req_i(req[2]), .slv2_val_i(val[2]), .slv2_data_i(data[2]),
    .slv2_prio_i(prio[2]), .slv2_pkglen_i(pkg[2]),
    .a2s0_ack_o(ack_o[0]), .a2s1_ack_o(ack_o[1]), .a2s2_ack_o(ack_o[2]),
    .f2a_ack_i(f2a_ack), .f2a_id_req_i(f2a_id_req),
    .a2f_id_o(id_o), .a2f_val_o(val_o), .a2f_data_o(data_o),
    .a2f_pkglen_sel_o(pk_o), .grant_cnt_o(cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mst = 0; mgrant = 3; mlast = 2; mpk = 3; mcnt = 0;
  endtask

  // Check outputs for the inputs currently applied, then advance one clock.
  task automatic step();
    logic busy;
    int e_val, e_data, e_ack;
    int nst, ngr, nla, npk, ncn, best, bkey, key;
    #2;
    busy = !rst_i && mst == 2;
    e_val = 0; e_data = 0; e_ack = 0;
    if (busy) begin
      e_val  = val[mgrant];
      e_data = data[mgrant];
      e_ack  = f2a_ack ? (1 << mgrant) : 0;
    end
    chk("id",     id_o,   busy ? mgrant : 3);
    chk("val",    val_o,  e_val);
    chk("data",   data_o, e_data);
    chk("acks",   ack_o,  e_ack);
    chk("pkglen", pk_o,   rst_i ? 3 : mpk);
    chk("cnt",    cnt_o,  mcnt);
    nst = mst; ngr = mgrant; nla = mlast; npk = mpk; ncn = mcnt;
    if (rst_i) begin
      nst = 0; ngr = 3; nla = 2; npk = 3; ncn = 0;
    end else begin
      case (mst)
        0: if (req != 0) nst = 1;
        1: begin
          // key: priority first, then distance after the last granted channel
          best = -1; bkey = 1000;
          for (int c = 0; c < 3; c++) begin
            key = prio[c] * 4 + (c - mlast + 5) % 3;
            if (req[c] && key < bkey) begin bkey = key; best = c; end
          end
          if (best < 0) nst = 0;
          else begin
            nst = 2; ngr = best; nla = best; npk = pkg[best];
            ncn = (mcnt < 65535) ? mcnt + 1 : mcnt;
          end
        end
        2: if (f2a_id_req) nst = 3;
        default: begin nst = 0; ngr = 3; end
      endcase
    end
    @(posedge clk_i);
    mst = nst; mgrant = ngr; mlast = nla; mpk = npk; mcnt = ncn;
    #1;
  endtask

  task automatic clear_in();
    rst_i = 0; req = 0; val = 0; f2a_ack = 0; f2a_id_req = 0;
    for (int c = 0; c < 3; c++) begin data[c] = '0; prio[c] = 0; pkg[c] = 0; end
  endtask

  task automatic do_reset();
    clear_in();
    rst_i = 1; step(); rst_i = 0;
  endtask

  // From BUSY: release and go round to the next grant (REL, IDLE, ARB, BUSY).
  task automatic regrant();
    f2a_id_req = 1; step(); f2a_id_req = 0;
    step(); step(); step();
  endtask

  initial begin
    clear_in();
    rst_i = 1;
    @(posedge clk_i); #1;
    model_reset();
    do_reset();
    chk("rst_id", id_o, 3); chk("rst_pk", pk_o, 3); chk("rst_cnt", cnt_o, 0);
    chk("rst_val", val_o, 0); chk("rst_acks", ack_o, 0);

    // single requester on ch1
    req = 3'b010; prio[1] = 2; pkg[1] = 1;
    step(); step();
    chk("r33_id", id_o, 1); chk("r33_pk", pk_o, 1); chk("r33_cnt", cnt_o, 1);

    // prio 3/1/1: ch1, then ch2, then ch1
    do_reset();
    req = 3'b111; prio[0] = 3; prio[1] = 1; prio[2] = 1;
    step(); step();
    chk("r34_g1", id_o, 1);
    regrant(); chk("r34_g2", id_o, 2);
    regrant(); chk("r34_g3", id_o, 1);

    // data path and acks on ch0
    do_reset();
    req = 3'b001; step(); step();
    f2a_ack = 1; val[0] = 1; data[0] = 32'hA5A5_0001; #1;
    chk("r35_ack", ack_o, 3'b001); chk("r35_data", data_o, 32'hA5A5_0001);
    step();

    // pkglen latched during ch2 grant
    do_reset();
    req = 3'b100; pkg[2] = 0; step(); step();
    pkg[2] = 3; step(); chk("r36_pk", pk_o, 0); step(); chk("r36_pk2", pk_o, 0);

    // one-cycle request pulse: back to IDLE with no grant
    do_reset();
    req = 3'b001; step(); req = 0; step();
    chk("r37_id", id_o, 3); chk("r37_cnt", cnt_o, 0); step();

    // reset mid-packet, then equal priority goes to ch0
    do_reset();
    req = 3'b001; step(); step();
    f2a_ack = 1; val[0] = 1; rst_i = 1; step(); rst_i = 0;
    chk("r38_id", id_o, 3); chk("r38_acks", ack_o, 0); chk("r38_cnt", cnt_o, 0);
    req = 3'b111; step(); step();
    chk("r38_g", id_o, 0);
    f2a_ack = 0; step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic eq;
      rst_i      = ($urandom % 80) == 0;
      f2a_ack    = $urandom % 2;
      f2a_id_req = ($urandom % 5) == 0;
      eq         = ($urandom % 3) == 0;
      for (int c = 0; c < 3; c++) begin
        req[c]  = ($urandom % 4) != 0;
        val[c]  = $urandom % 2;
        data[c] = $urandom;
        prio[c] = eq ? prio[0] : 2'($urandom % 4);
        pkg[c]  = 3'($urandom % 8);
      end
      if (eq) begin prio[1] = prio[0]; prio[2] = prio[0]; end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
